commit_stream_checker: RTL and testbench
========================================

// Module: commit_stream_checker
// PURPOSE
// - Synthesizable, parametrised commit-stream checker and watchdog for the OoO core.
// - Sits beside the ROB commit port; watches COMMIT_W commit lanes plus flush and fetch.
// - Checks lane contiguity, ROB-index sequencing and PC sequencing, and detects pipeline deadlock.
// - Keeps retire/cycle/idle counters. Latches the first error and freezes until cleared.
// PARAMETERS
// - COMMIT_W     2     number of commit lanes checked per cycle
// - ROB_DEPTH    16    ROB entries; power of 2; index width ROB_IDX_W = $clog2(ROB_DEPTH)
// - PC_W         32    commit/flush PC width
// - WDOG_CYCLES  64    cycles without a commit, while RUN, before a timeout error
// - CNT_W        32    width of all performance counters
// PORTS
// - clk                 in   1                      core clock
// - reset               in   1                      asynchronous, active-high reset
// - commit_valid        in   COMMIT_W               per-lane commit strobe
// - commit_rob_idx      in   COMMIT_W x ROB_IDX_W   ROB index retired on each lane
// - commit_pc           in   COMMIT_W x PC_W        PC retired on each lane
// - commit_is_branch    in   COMMIT_W               lane retires a control-flow instruction
// - flush               in   1                      pipeline flush strobe
// - flush_pc            in   PC_W                   redirect target of the flush
// - err_clear           in   1                      one-cycle pulse: clear errors, return to IDLE
// - chk_state           out  2                      IDLE=0, RUN=1, ERROR=2
// - err_flags           out  4                      sticky: [0] LANE_GAP [1] ROB_SEQ [2] PC_SEQ [3] TIMEOUT
// - err_valid           out  1                      err_flags != 0
// - first_err_pc        out  PC_W                   PC of the lane that raised the first error (0 for TIMEOUT)
// - first_err_cycle     out  CNT_W                  cycle_cnt value when the first error was latched
// - retired_cnt         out  CNT_W                  total instructions committed
// - cycle_cnt           out  CNT_W                  cycles spent in RUN
// - idle_cnt            out  CNT_W                  RUN cycles with no commit
// BEHAVIOUR
// - Reset: every output is 0 and state is IDLE.
//   Internal state also clears: exp_rob_idx=0, exp_pc=0, pc_known=0, wdog=0.
// - All outputs are registered. An error seen in cycle N shows in err_flags at N+1.
// - Per cycle, n = popcount(commit_valid).
// - LANE_GAP: commit_valid must be a thermometer code from lane 0 (01, 11 legal; 10 illegal).
// - ROB_SEQ: each valid lane i must satisfy commit_rob_idx[i] == (exp_rob_idx + i) mod ROB_DEPTH.
//   - exp_rob_idx advances by n, with wrap-around.
//   - The first commit in IDLE seeds exp_rob_idx from lane 0 and is not checked.
// - PC_SEQ, checked only when pc_known:
//   - The expected PC for lane 0 is exp_pc.
//   - The expected PC for lane i>0 is commit_pc[i-1]+4, unless lane i-1 is a branch.
//   - A lane that follows a branch may have any PC.
//   - After the cycle: exp_pc = last valid pc + 4, and pc_known = !last_is_branch.
// - Flush in the same cycle as commits:
//   - The commits are checked first.
//   - Then exp_pc = flush_pc and pc_known = 1.
//   - exp_rob_idx is unchanged, because the ROB head is unaffected by a flush.
// - Watchdog:
//   - wdog counts RUN cycles with n == 0 and saturates at WDOG_CYCLES.
//   - Any commit clears it to 0.
//   - Reaching WDOG_CYCLES sets TIMEOUT.
// - FSM transitions:
//   - IDLE -> RUN on the first commit; counters start counting that cycle.
//   - RUN -> ERROR when any check fails.
//   - ERROR -> IDLE on err_clear.
// - In ERROR:
//   - All counters, first_err_* and wdog freeze.
//   - Further errors OR into err_flags but do not overwrite first_err_*.
// - Multiple errors in one cycle: all flags are set. first_err_pc comes from the lowest failing lane.
// - err_clear:
//   - Clears err_flags, first_err_*, wdog and pc_known.
//   - Keeps the counters and exp_rob_idx.
//   - err_clear in RUN or IDLE only clears; an error in the same cycle still latches.
// - Counters wrap modulo 2^CNT_W.
// - Reset asserted mid-run returns everything to reset values at once.
// STRUCTURE
// - commit_chk_pkg: chk_state_e enum, ERR_* bit indices, ERR_W=4 constant.
// - Sub-module commit_lane_check (combinational, one per lane):
//   - Inputs: lane data, expected index/PC and predecessor info.
//   - Outputs: rob_ok, pc_ok, next_pc.
// - Top level: contiguity/popcount, FSM, watchdog, counters, first-error capture.
// TESTING
// - After reset, lanes retire ROB 0..3 at PC 0x00..0x0C, 2 per cycle
//   -> err_flags=0, retired_cnt=4, state=RUN.
// - Commit ROB 14,15,0,1 (ROB_DEPTH=16) with sequential PCs
//   -> no ROB_SEQ; exp_rob_idx=2.
// - commit_valid=2'b10 at PC 0x20 -> err_flags=4'b0001, state=ERROR, first_err_pc=0x20.
//   - Then err_clear -> flags=0, state=IDLE.
// - Lane 0 is a branch at PC 0x08 and lane 1 has PC 0x40 -> no PC_SEQ.
//   - Next cycle PC 0x48 with no branch -> PC_SEQ, first_err_pc=0x48.
// - flush with flush_pc=0x100 in the same cycle as a commit at 0x10
//   -> next commit at 0x100 passes and one at 0x14 sets PC_SEQ.
// - Commit once, then 64 idle cycles -> TIMEOUT at cycle 64+1, idle_cnt=64, counters frozen after.

Source files
------------

// File: rtl/commit_chk_pkg.sv
// ----------------------------------------------------------------------------
// commit_chk_pkg
// Shared definitions for the commit-stream checker.
//   chk_state_e : checker FSM encoding, as seen on o_chk_state
//   ERR_*       : bit positions inside the sticky error-flag vector
//   ERR_W       : width of the error-flag vector
// ----------------------------------------------------------------------------
package commit_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ERROR = 2'd2
   } chk_state_e;

   localparam int ERR_W        = 4;
   localparam int ERR_LANE_GAP = 0;
   localparam int ERR_ROB_SEQ  = 1;
   localparam int ERR_PC_SEQ   = 2;
   localparam int ERR_TIMEOUT  = 3;

endpackage : commit_chk_pkg

// File: rtl/commit_lane_check.sv
// ----------------------------------------------------------------------------
// commit_lane_check
// Combinational check of one commit lane against the expected ROB index and PC.
//   i_valid / i_rob_idx / i_pc      : this lane's commit data
//   i_exp_rob_idx                   : ROB index this lane must carry
//   i_exp_pc / i_pc_known           : cross-cycle expected PC and whether it is trusted
//   i_prev_valid/_pc/_is_branch     : the lane immediately below (tie off for lane 0)
//   o_rob_ok / o_pc_ok              : 1 when the lane is idle or passes the check
//   o_next_pc                       : sequential successor of this lane's PC
// ----------------------------------------------------------------------------
module commit_lane_check #(
   parameter int ROB_IDX_W = 4,
   parameter int PC_W      = 32
) (
   input  logic                 i_valid,
   input  logic [ROB_IDX_W-1:0] i_rob_idx,
   input  logic [PC_W-1:0]      i_pc,
   input  logic [ROB_IDX_W-1:0] i_exp_rob_idx,
   input  logic [PC_W-1:0]      i_exp_pc,
   input  logic                 i_pc_known,
   input  logic                 i_prev_valid,
   input  logic [PC_W-1:0]      i_prev_pc,
   input  logic                 i_prev_is_branch,
   output logic                 o_rob_ok,
   output logic                 o_pc_ok,
   output logic [PC_W-1:0]      o_next_pc
);

   logic [PC_W-1:0] w_exp_pc;
   logic            w_pc_chk;

   // A valid lane below us defines our expected PC; otherwise fall back to the
   // PC carried over from the previous cycle. Anything after a branch is free.
   always_comb begin
      w_exp_pc = i_prev_valid ? (i_prev_pc + PC_W'(4)) : i_exp_pc;
      w_pc_chk = i_pc_known & ~(i_prev_valid & i_prev_is_branch);
   end

   assign o_rob_ok  = ~i_valid | (i_rob_idx == i_exp_rob_idx);
   assign o_pc_ok   = ~i_valid | ~w_pc_chk | (i_pc == w_exp_pc);
   assign o_next_pc = i_pc + PC_W'(4);

endmodule : commit_lane_check

// File: rtl/commit_stream_checker.sv
// ----------------------------------------------------------------------------
// commit_stream_checker
// Watches the ROB commit port, flush and PC stream; flags lane gaps, ROB-index
// and PC sequencing errors and commit starvation. Latches the first error and
// freezes counters until i_err_clear.
//   i_clk, i_reset (async, active high)
//   i_commit_valid/_rob_idx/_pc/_is_branch : COMMIT_W commit lanes
//   i_flush, i_flush_pc                    : redirect strobe and target
//   i_err_clear                            : clear errors, return to IDLE
//   o_chk_state                            : IDLE=0 RUN=1 ERROR=2
//   o_err_flags, o_err_valid               : sticky flags and their OR
//   o_first_err_pc, o_first_err_cycle      : capture of the first error
//   o_retired_cnt, o_cycle_cnt, o_idle_cnt : performance counters
// ----------------------------------------------------------------------------
module commit_stream_checker
   import commit_chk_pkg::*;
#(
   parameter  int COMMIT_W    = 2,
   parameter  int ROB_DEPTH   = 16,
   parameter  int PC_W        = 32,
   parameter  int WDOG_CYCLES = 64,
   parameter  int CNT_W       = 32,
   localparam int ROB_IDX_W   = $clog2(ROB_DEPTH)
) (
   input  logic                               i_clk,
   input  logic                               i_reset,
   input  logic [COMMIT_W-1:0]                i_commit_valid,
   input  logic [COMMIT_W-1:0][ROB_IDX_W-1:0] i_commit_rob_idx,
   input  logic [COMMIT_W-1:0][PC_W-1:0]      i_commit_pc,
   input  logic [COMMIT_W-1:0]                i_commit_is_branch,
   input  logic                               i_flush,
   input  logic [PC_W-1:0]                    i_flush_pc,
   input  logic                               i_err_clear,
   output logic [1:0]                         o_chk_state,
   output logic [ERR_W-1:0]                   o_err_flags,
   output logic                               o_err_valid,
   output logic [PC_W-1:0]                    o_first_err_pc,
   output logic [CNT_W-1:0]                   o_first_err_cycle,
   output logic [CNT_W-1:0]                   o_retired_cnt,
   output logic [CNT_W-1:0]                   o_cycle_cnt,
   output logic [CNT_W-1:0]                   o_idle_cnt
);

   localparam int N_W  = $clog2(COMMIT_W + 1);
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);

   // registered state
   chk_state_e           r_state,           r_state_next;
   logic [ERR_W-1:0]     r_err_flags,       r_err_flags_next;
   logic                 r_err_valid;
   logic [PC_W-1:0]      r_first_err_pc,    r_first_err_pc_next;
   logic [CNT_W-1:0]     r_first_err_cycle, r_first_err_cycle_next;
   logic [CNT_W-1:0]     r_retired_cnt,     r_retired_cnt_next;
   logic [CNT_W-1:0]     r_cycle_cnt,       r_cycle_cnt_next;
   logic [CNT_W-1:0]     r_idle_cnt,        r_idle_cnt_next;
   logic [ROB_IDX_W-1:0] r_exp_rob_idx,     r_exp_rob_idx_next;
   logic [PC_W-1:0]      r_exp_pc,          r_exp_pc_next;
   logic                 r_pc_known,        r_pc_known_next;
   logic [WD_W-1:0]      r_wdog,            r_wdog_next;

   // lane results
   logic [ROB_IDX_W-1:0]              w_rob_base;
   logic [COMMIT_W-1:0][ROB_IDX_W-1:0] w_exp_idx;
   logic [COMMIT_W-1:0]               w_prev_valid, w_prev_branch, w_gap;
   logic [COMMIT_W-1:0][PC_W-1:0]     w_prev_pc, w_next_pc;
   logic [COMMIT_W-1:0]               w_rob_ok, w_pc_ok, w_lane_fail;

   // cycle summary
   logic [N_W-1:0]   w_n;
   logic [PC_W-1:0]  w_last_next_pc;
   logic             w_last_branch;
   logic [PC_W-1:0]  w_fail_pc;
   logic             w_timeout;
   logic             w_active;
   logic [ERR_W-1:0] w_new_err;

   // The first commit out of IDLE seeds the ROB sequence from lane 0.
   assign w_rob_base = (r_state == ST_IDLE) ? i_commit_rob_idx[0] : r_exp_rob_idx;

   genvar gi;
   generate
      for (gi = 0; gi < COMMIT_W; gi++) begin : g_lane
         if (gi == 0) begin : g_first
            assign w_prev_valid[gi]  = 1'b0;
            assign w_prev_branch[gi] = 1'b0;
            assign w_prev_pc[gi]     = '0;
            assign w_gap[gi]         = 1'b0;
         end else begin : g_rest
            assign w_prev_valid[gi]  = i_commit_valid[gi-1];
            assign w_prev_branch[gi] = i_commit_is_branch[gi-1];
            assign w_prev_pc[gi]     = i_commit_pc[gi-1];
            assign w_gap[gi]         = i_commit_valid[gi] & ~i_commit_valid[gi-1];
         end

         assign w_exp_idx[gi] = w_rob_base + ROB_IDX_W'(gi);

         commit_lane_check #(
            .ROB_IDX_W (ROB_IDX_W),
            .PC_W      (PC_W)
         ) u_lane (
            .i_valid          (i_commit_valid[gi]),
            .i_rob_idx        (i_commit_rob_idx[gi]),
            .i_pc             (i_commit_pc[gi]),
            .i_exp_rob_idx    (w_exp_idx[gi]),
            .i_exp_pc         (r_exp_pc),
            .i_pc_known       (r_pc_known),
            .i_prev_valid     (w_prev_valid[gi]),
            .i_prev_pc        (w_prev_pc[gi]),
            .i_prev_is_branch (w_prev_branch[gi]),
            .o_rob_ok         (w_rob_ok[gi]),
            .o_pc_ok          (w_pc_ok[gi]),
            .o_next_pc        (w_next_pc[gi])
         );

         assign w_lane_fail[gi] = w_gap[gi] | ~w_rob_ok[gi] | ~w_pc_ok[gi];
      end
   endgenerate

   // Popcount, last valid lane, and PC of the lowest failing lane.
   always_comb begin
      w_n            = '0;
      w_last_next_pc = r_exp_pc;
      w_last_branch  = 1'b0;
      w_fail_pc      = '0;
      for (int i = 0; i < COMMIT_W; i++) begin
         if (i_commit_valid[i]) begin
            w_n            = w_n + N_W'(1);
            w_last_next_pc = w_next_pc[i];
            w_last_branch  = i_commit_is_branch[i];
         end
      end
      for (int i = COMMIT_W - 1; i >= 0; i--) begin
         if (w_lane_fail[i]) begin
            w_fail_pc = i_commit_pc[i];
         end
      end
   end

   // wdog already holds WDOG_CYCLES-1 idle cycles; this idle cycle completes it.
   assign w_timeout = (r_state == ST_RUN) && (w_n == '0) &&
                      (r_wdog == WD_W'(WDOG_CYCLES - 1));
   assign w_active  = (r_state == ST_RUN) || ((r_state == ST_IDLE) && (w_n != '0));

   always_comb begin
      w_new_err               = '0;
      w_new_err[ERR_LANE_GAP] = |w_gap;
      w_new_err[ERR_ROB_SEQ]  = ~&w_rob_ok;
      w_new_err[ERR_PC_SEQ]   = ~&w_pc_ok;
      w_new_err[ERR_TIMEOUT]  = w_timeout;
   end

   always_comb begin
      r_state_next           = r_state;
      r_err_flags_next       = r_err_flags;
      r_first_err_pc_next    = r_first_err_pc;
      r_first_err_cycle_next = r_first_err_cycle;
      r_retired_cnt_next     = r_retired_cnt;
      r_cycle_cnt_next       = r_cycle_cnt;
      r_idle_cnt_next        = r_idle_cnt;
      r_exp_rob_idx_next     = r_exp_rob_idx;
      r_exp_pc_next          = r_exp_pc;
      r_pc_known_next        = r_pc_known;
      r_wdog_next            = r_wdog;

      // Sequence tracking continues in every state so ERROR can keep flagging.
      if (w_n != '0) begin
         r_exp_rob_idx_next = w_rob_base + ROB_IDX_W'(w_n);
         r_exp_pc_next      = w_last_next_pc;
         r_pc_known_next    = ~w_last_branch;
      end
      // Flush redirects the PC only; the ROB head does not move.
      if (i_flush) begin
         r_exp_pc_next   = i_flush_pc;
         r_pc_known_next = 1'b1;
      end

      if (w_active) begin
         r_cycle_cnt_next   = r_cycle_cnt + CNT_W'(1);
         r_retired_cnt_next = r_retired_cnt + CNT_W'(w_n);
         if (w_n == '0) begin
            r_idle_cnt_next = r_idle_cnt + CNT_W'(1);
            if (r_wdog != WD_W'(WDOG_CYCLES)) begin
               r_wdog_next = r_wdog + WD_W'(1);
            end
         end else begin
            r_wdog_next = '0;
         end
      end

      if (r_state == ST_ERROR) begin
         if (i_err_clear) begin
            r_state_next           = ST_IDLE;
            r_err_flags_next       = '0;
            r_first_err_pc_next    = '0;
            r_first_err_cycle_next = '0;
            r_wdog_next            = '0;
            r_pc_known_next        = 1'b0;
         end else begin
            r_err_flags_next = r_err_flags | w_new_err;
         end
      end else begin
         if ((r_state == ST_IDLE) && (w_n != '0)) begin
            r_state_next = ST_RUN;
         end
         if (i_err_clear) begin
            r_wdog_next     = '0;
            r_pc_known_next = 1'b0;
         end
         // Outside ERROR no flag is set, so any new error is the first one.
         r_err_flags_next = w_new_err;
         if (w_new_err != '0) begin
            r_state_next           = ST_ERROR;
            r_first_err_pc_next    = w_new_err[ERR_TIMEOUT] ? '0 : w_fail_pc;
            r_first_err_cycle_next = r_cycle_cnt_next;
         end else begin
            r_first_err_pc_next    = '0;
            r_first_err_cycle_next = '0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state           <= ST_IDLE;
         r_err_flags       <= '0;
         r_err_valid       <= 1'b0;
         r_first_err_pc    <= '0;
         r_first_err_cycle <= '0;
         r_retired_cnt     <= '0;
         r_cycle_cnt       <= '0;
         r_idle_cnt        <= '0;
         r_exp_rob_idx     <= '0;
         r_exp_pc          <= '0;
         r_pc_known        <= 1'b0;
         r_wdog            <= '0;
      end else begin
         r_state           <= r_state_next;
         r_err_flags       <= r_err_flags_next;
         r_err_valid       <= |r_err_flags_next;
         r_first_err_pc    <= r_first_err_pc_next;
         r_first_err_cycle <= r_first_err_cycle_next;
         r_retired_cnt     <= r_retired_cnt_next;
         r_cycle_cnt       <= r_cycle_cnt_next;
         r_idle_cnt        <= r_idle_cnt_next;
         r_exp_rob_idx     <= r_exp_rob_idx_next;
         r_exp_pc          <= r_exp_pc_next;
         r_pc_known        <= r_pc_known_next;
         r_wdog            <= r_wdog_next;
      end
   end

   assign o_chk_state       = r_state;
   assign o_err_flags       = r_err_flags;
   assign o_err_valid       = r_err_valid;
   assign o_first_err_pc    = r_first_err_pc;
   assign o_first_err_cycle = r_first_err_cycle;
   assign o_retired_cnt     = r_retired_cnt;
   assign o_cycle_cnt       = r_cycle_cnt;
   assign o_idle_cnt        = r_idle_cnt;

endmodule : commit_stream_checker

// File: tb/tb_commit_stream_checker.sv
// ----------------------------------------------------------------------------
// tb_commit_stream_checker
// Directed stimulus for commit_stream_checker (COMMIT_W=2, ROB_DEPTH=16,
// PC_W=32, WDOG_CYCLES=64, CNT_W=32). Each step drives one cycle of commit
// traffic, queues the expected register outputs and compares them one time
// unit after the clock edge that latches them.
// ----------------------------------------------------------------------------
module tb_commit_stream_checker;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_ERR  = 2'd2;

   logic             clk;
   logic             reset;
   logic [1:0]       commit_valid;
   logic [1:0][3:0]  commit_rob_idx;
   logic [1:0][31:0] commit_pc;
   logic [1:0]       commit_is_branch;
   logic             flush;
   logic [31:0]      flush_pc;
   logic             err_clear;
   logic [1:0]       chk_state;
   logic [3:0]       err_flags;
   logic             err_valid;
   logic [31:0]      first_err_pc;
   logic [31:0]      first_err_cycle;
   logic [31:0]      retired_cnt;
   logic [31:0]      cycle_cnt;
   logic [31:0]      idle_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [1:0]  st;
      logic [3:0]  flags;
      logic [31:0] fpc;
      logic [31:0] fcyc;
      logic [31:0] ret;
      logic [31:0] cyc;
      logic [31:0] idle;
   } exp_t;

   exp_t sb_q[$];

   commit_stream_checker #(
      .COMMIT_W    (2),
      .ROB_DEPTH   (16),
      .PC_W        (32),
      .WDOG_CYCLES (64),
      .CNT_W       (32)
   ) dut (
      .i_clk              (clk),
      .i_reset            (reset),
      .i_commit_valid     (commit_valid),
      .i_commit_rob_idx   (commit_rob_idx),
      .i_commit_pc        (commit_pc),
      .i_commit_is_branch (commit_is_branch),
      .i_flush            (flush),
      .i_flush_pc         (flush_pc),
      .i_err_clear        (err_clear),
      .o_chk_state        (chk_state),
      .o_err_flags        (err_flags),
      .o_err_valid        (err_valid),
      .o_first_err_pc     (first_err_pc),
      .o_first_err_cycle  (first_err_cycle),
      .o_retired_cnt      (retired_cnt),
      .o_cycle_cnt        (cycle_cnt),
      .o_idle_cnt         (idle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL sim_timeout observed=running required=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs(input exp_t e);
      chk({e.tag, ".state"},     32'(chk_state),       32'(e.st));
      chk({e.tag, ".flags"},     32'(err_flags),       32'(e.flags));
      chk({e.tag, ".err_valid"}, 32'(err_valid),       32'(e.flags != 4'd0));
      chk({e.tag, ".first_pc"},  first_err_pc,         e.fpc);
      chk({e.tag, ".first_cyc"}, first_err_cycle,      e.fcyc);
      chk({e.tag, ".retired"},   retired_cnt,          e.ret);
      chk({e.tag, ".cycles"},    cycle_cnt,            e.cyc);
      chk({e.tag, ".idle"},      idle_cnt,             e.idle);
      $display("step %-10s state=%0d flags=%b fpc=0x%0h fcyc=%0d ret=%0d cyc=%0d idle=%0d",
               e.tag, chk_state, err_flags, first_err_pc, first_err_cycle,
               retired_cnt, cycle_cnt, idle_cnt);
   endtask

   // One clock of stimulus; the expectation is queued as the stimulus is driven.
   task automatic step(input string tag, input logic [1:0] v,
                       input logic [3:0] r0, input logic [3:0] r1,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] br, input logic fl, input logic [31:0] fpc_in,
                       input logic clr,
                       input logic [1:0] e_st, input logic [3:0] e_fl,
                       input logic [31:0] e_fpc, input logic [31:0] e_fcyc,
                       input logic [31:0] e_ret, input logic [31:0] e_cyc,
                       input logic [31:0] e_idle);
      exp_t e;
      commit_valid      = v;
      commit_rob_idx[0] = r0;
      commit_rob_idx[1] = r1;
      commit_pc[0]      = p0;
      commit_pc[1]      = p1;
      commit_is_branch  = br;
      flush             = fl;
      flush_pc          = fpc_in;
      err_clear         = clr;
      e = '{tag: tag, st: e_st, flags: e_fl, fpc: e_fpc, fcyc: e_fcyc,
            ret: e_ret, cyc: e_cyc, idle: e_idle};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      commit_valid = 2'b00;
      flush        = 1'b0;
      err_clear    = 1'b0;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         check_outputs(sb_q.pop_front());
      end
   endtask

   // Idle cycle (no commit) with optional err_clear.
   task automatic idle_step(input string tag, input logic clr,
                            input logic [1:0] e_st, input logic [3:0] e_fl,
                            input logic [31:0] e_fpc, input logic [31:0] e_fcyc,
                            input logic [31:0] e_ret, input logic [31:0] e_cyc,
                            input logic [31:0] e_idle);
      step(tag, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 2'b00, 1'b0, 32'd0, clr,
           e_st, e_fl, e_fpc, e_fcyc, e_ret, e_cyc, e_idle);
   endtask

   initial begin
      exp_t zero_e;
      reset            = 1'b1;
      commit_valid     = 2'b00;
      commit_rob_idx   = '0;
      commit_pc        = '0;
      commit_is_branch = 2'b00;
      flush            = 1'b0;
      flush_pc         = 32'd0;
      err_clear        = 1'b0;
      zero_e = '{tag: "reset", st: S_IDLE, flags: 4'd0, fpc: 32'd0, fcyc: 32'd0,
                 ret: 32'd0, cyc: 32'd0, idle: 32'd0};

      repeat (3) @(posedge clk);
      #1;
      check_outputs(zero_e);
      reset = 1'b0;

      // ROB 0..3 at PC 0x00..0x0C, two per cycle
      step("s1", 2'b11, 4'd0, 4'd1, 32'h00, 32'h04, 2'b00, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0);
      step("s2", 2'b11, 4'd2, 4'd3, 32'h08, 32'h0C, 2'b00, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd4, 32'd2, 32'd0);

      // walk the ROB up to index 13
      for (int k = 0; k < 5; k++) begin
         step("walk", 2'b11, 4'(4 + 2 * k), 4'(5 + 2 * k),
              32'(32'h10 + 8 * k), 32'(32'h14 + 8 * k), 2'b00, 1'b0, 32'd0, 1'b0,
              S_RUN, 4'b0000, 32'd0, 32'd0, 32'(6 + 2 * k), 32'(3 + k), 32'd0);
      end

      // ROB wrap 14,15,0,1
      step("wrap_a", 2'b11, 4'd14, 4'd15, 32'h38, 32'h3C, 2'b00, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd16, 32'd8, 32'd0);
      step("wrap_b", 2'b11, 4'd0, 4'd1, 32'h40, 32'h44, 2'b00, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd18, 32'd9, 32'd0);
      // ROB 2 is next after the wrap; flush redirects to 0x20
      step("rob2_fl", 2'b01, 4'd2, 4'd0, 32'h48, 32'h00, 2'b00, 1'b1, 32'h20, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd19, 32'd10, 32'd0);

      // lane gap 2'b10 with otherwise correct ROB/PC
      step("lane_gap", 2'b10, 4'd0, 4'd4, 32'h00, 32'h20, 2'b00, 1'b0, 32'd0, 1'b0,
           S_ERR, 4'b0001, 32'h20, 32'd11, 32'd20, 32'd11, 32'd0);
      idle_step("err_hold", 1'b0, S_ERR, 4'b0001, 32'h20, 32'd11, 32'd20, 32'd11, 32'd0);
      // wrong ROB index in ERROR: ORs in, capture and counters stay
      step("err_or", 2'b01, 4'd9, 4'd0, 32'h24, 32'h00, 2'b00, 1'b0, 32'd0, 1'b0,
           S_ERR, 4'b0011, 32'h20, 32'd11, 32'd20, 32'd11, 32'd0);
      idle_step("clear1", 1'b1, S_IDLE, 4'b0000, 32'd0, 32'd0, 32'd20, 32'd11, 32'd0);

      // branch on lane 0 frees lane 1; following non-branch PC must be sequential
      step("seed2", 2'b01, 4'd5, 4'd0, 32'h04, 32'h00, 2'b00, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd21, 32'd12, 32'd0);
      step("branch", 2'b11, 4'd6, 4'd7, 32'h08, 32'h40, 2'b01, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd23, 32'd13, 32'd0);
      step("pc_seq", 2'b01, 4'd8, 4'd0, 32'h48, 32'h00, 2'b00, 1'b0, 32'd0, 1'b0,
           S_ERR, 4'b0100, 32'h48, 32'd14, 32'd24, 32'd14, 32'd0);
      idle_step("clear2", 1'b1, S_IDLE, 4'b0000, 32'd0, 32'd0, 32'd24, 32'd14, 32'd0);

      // flush in the same cycle as a commit
      step("fl_seed", 2'b01, 4'd9, 4'd0, 32'h0C, 32'h00, 2'b00, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd25, 32'd15, 32'd0);
      step("fl_commit", 2'b01, 4'd10, 4'd0, 32'h10, 32'h00, 2'b00, 1'b1, 32'h100, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd26, 32'd16, 32'd0);
      step("fl_target", 2'b01, 4'd11, 4'd0, 32'h100, 32'h00, 2'b00, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd27, 32'd17, 32'd0);
      step("fl_again", 2'b01, 4'd12, 4'd0, 32'h104, 32'h00, 2'b00, 1'b1, 32'h100, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd28, 32'd18, 32'd0);
      step("fl_stale", 2'b01, 4'd13, 4'd0, 32'h14, 32'h00, 2'b00, 1'b0, 32'd0, 1'b0,
           S_ERR, 4'b0100, 32'h14, 32'd19, 32'd29, 32'd19, 32'd0);
      idle_step("clear3", 1'b1, S_IDLE, 4'b0000, 32'd0, 32'd0, 32'd29, 32'd19, 32'd0);

      // watchdog: one commit then 64 idle cycles
      step("wd_seed", 2'b01, 4'd14, 4'd0, 32'h200, 32'h00, 2'b00, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd30, 32'd20, 32'd0);
      for (int i = 1; i < 64; i++) begin
         idle_step("wd_idle", 1'b0, S_RUN, 4'b0000, 32'd0, 32'd0, 32'd30,
                   32'(20 + i), 32'(i));
      end
      idle_step("timeout", 1'b0, S_ERR, 4'b1000, 32'd0, 32'd84, 32'd30, 32'd84, 32'd64);
      idle_step("frozen1", 1'b0, S_ERR, 4'b1000, 32'd0, 32'd84, 32'd30, 32'd84, 32'd64);
      idle_step("frozen2", 1'b0, S_ERR, 4'b1000, 32'd0, 32'd84, 32'd30, 32'd84, 32'd64);
      idle_step("clear4", 1'b1, S_IDLE, 4'b0000, 32'd0, 32'd0, 32'd30, 32'd84, 32'd64);

      // asynchronous reset in the middle of a run
      step("rs_seed", 2'b01, 4'd15, 4'd0, 32'h300, 32'h00, 2'b00, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd31, 32'd85, 32'd64);
      #2;
      reset = 1'b1;
      #1;
      zero_e.tag = "mid_reset";
      check_outputs(zero_e);
      @(negedge clk);
      reset = 1'b0;
      step("post_rst", 2'b11, 4'd7, 4'd8, 32'h10, 32'h14, 2'b00, 1'b0, 32'd0, 1'b0,
           S_RUN, 4'b0000, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_commit_stream_checker
